// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin sharing of one floating-point add/sub
// datapath between two requesters. Operands are registered on accept, the
// datapath is given DP_LATENCY+1 cycles, and the captured result is returned
// on the owner's response channel. Results pass through bit-exact.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; grant alternates on a tie
// EXEC  | operands on dp_*; wait counter runs down, then capture
// RESP  | owner's rsp_valid high until its rsp_ready handshake
module fp_addsub_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DP_LATENCY = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_op,
  input  logic [WIDTH-1:0] dp_result,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int LAT_W = (DP_LATENCY > 0) ? $clog2(DP_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(DP_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic             r_owner;
  logic [LAT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [WIDTH-1:0] r_res0;
  logic [WIDTH-1:0] r_res1;
  logic [CNT_W-1:0] r_ops_done;

  logic w_grant1;
  logic w_accept;
  logic w_capture;
  logic w_rsp_hs;

  // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
  assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake outputs. Ready is held low while reset is
  // asserted even though the state already reads IDLE.
  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_rsp_hs   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          req0_ready = !w_grant1;
          req1_ready = w_grant1;
          w_accept   = 1'b1;
          w_next     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        rsp0_valid = !r_owner;
        rsp1_valid = r_owner;
        w_rsp_hs   = r_owner ? rsp1_ready : rsp0_ready;
        if (w_rsp_hs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, grant history and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else if (w_accept) begin
      r_a          <= w_grant1 ? req1_a  : req0_a;
      r_b          <= w_grant1 ? req1_b  : req0_b;
      r_op         <= w_grant1 ? req1_op : req0_op;
      r_owner      <= w_grant1;
      r_last_grant <= w_grant1;
      r_cnt        <= LAT_LOAD;
    end else if (r_state == S_EXEC && r_cnt != '0) begin
      r_cnt <= r_cnt - LAT_W'(1);
    end
  end

  // Per-port result registers: the non-owner keeps its last delivered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res0 <= '0;
      r_res1 <= '0;
    end else if (w_capture) begin
      if (r_owner) r_res1 <= dp_result;
      else         r_res0 <= dp_result;
    end
  end

  // Completed-response counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ops_done <= '0;
    else if (w_rsp_hs) r_ops_done <= r_ops_done + CNT_W'(1);
  end

  assign dp_a        = r_a;
  assign dp_b        = r_b;
  assign dp_op       = r_op;
  assign rsp0_result = r_res0;
  assign rsp1_result = r_res1;
  assign busy        = (r_state != S_IDLE);
  assign ops_done    = r_ops_done;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter: one instance with a combinational
// datapath, one with DP_LATENCY=3 whose dp_result is driven per cycle.
module tb_fp_addsub_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Instance with combinational datapath.
  logic        req0_valid, req0_op, req1_valid, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] dp_a, dp_b, dp_result;
  logic        dp_op, busy;
  logic [15:0] ops_done;

  // Instance with three extra datapath cycles.
  logic        x3_req0_valid, x3_req0_op, x3_req1_valid, x3_req1_op;
  logic [31:0] x3_req0_a, x3_req0_b, x3_req1_a, x3_req1_b;
  logic        x3_req0_ready, x3_req1_ready;
  logic        x3_rsp0_valid, x3_rsp1_valid, x3_rsp0_ready, x3_rsp1_ready;
  logic [31:0] x3_rsp0_result, x3_rsp1_result;
  logic [31:0] x3_dp_a, x3_dp_b, x3_dp_result;
  logic        x3_dp_op, x3_busy;
  logic [15:0] x3_ops_done;

  fp_addsub_arbiter #(.WIDTH(32), .DP_LATENCY(0), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op), .dp_result(dp_result),
    .busy(busy), .ops_done(ops_done)
  );

  fp_addsub_arbiter #(.WIDTH(32), .DP_LATENCY(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(x3_req0_valid), .req0_ready(x3_req0_ready), .req0_a(x3_req0_a), .req0_b(x3_req0_b), .req0_op(x3_req0_op),
    .req1_valid(x3_req1_valid), .req1_ready(x3_req1_ready), .req1_a(x3_req1_a), .req1_b(x3_req1_b), .req1_op(x3_req1_op),
    .rsp0_valid(x3_rsp0_valid), .rsp0_ready(x3_rsp0_ready), .rsp0_result(x3_rsp0_result),
    .rsp1_valid(x3_rsp1_valid), .rsp1_ready(x3_rsp1_ready), .rsp1_result(x3_rsp1_result),
    .dp_a(x3_dp_a), .dp_b(x3_dp_b), .dp_op(x3_dp_op), .dp_result(x3_dp_result),
    .busy(x3_busy), .ops_done(x3_ops_done)
  );

  // Stand-in datapath: answers only the operand pairs used below.
  function automatic logic [31:0] fake_dp(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3FC0_0000 && b == 32'h4010_0000 && op)  return 32'h4070_0000;
    if (a == 32'h40A0_0000 && b == 32'h3F80_0000 && !op) return 32'h4080_0000;
    return 32'hBAD0_0000 ^ a;
  endfunction

  always_comb dp_result = fake_dp(dp_a, dp_b, dp_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    x3_req0_valid = 0; x3_req0_op = 0; x3_req0_a = 0; x3_req0_b = 0;
    x3_req1_valid = 0; x3_req1_op = 0; x3_req1_a = 0; x3_req1_b = 0;
    x3_rsp0_ready = 0; x3_rsp1_ready = 0; x3_dp_result = 0;

    // Reset: ready held low even with a request present.
    #12;
    req0_valid = 1;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    req0_valid = 0;
    @(negedge clk) rst_n = 1;
    cyc();

    // Single add on requester 0.
    req0_valid = 1; req0_a = 32'h3FC0_0000; req0_b = 32'h4010_0000; req0_op = 1;
    rsp0_ready = 1;
    #1;
    chk("add_req0_ready", req0_ready, 1);
    chk("add_req1_ready", req1_ready, 0);
    cyc();
    req0_valid = 0;
    chk("add_exec_busy", busy, 1);
    chk("add_dp_a", dp_a, 32'h3FC0_0000);
    chk("add_dp_b", dp_b, 32'h4010_0000);
    chk("add_dp_op", dp_op, 1);
    chk("add_exec_rsp0_valid", rsp0_valid, 0);
    cyc();
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_rsp0_result", rsp0_result, 32'h4070_0000);
    chk("add_rsp1_valid", rsp1_valid, 0);
    cyc();
    chk("add_done_rsp0_valid", rsp0_valid, 0);
    chk("add_ops_done", ops_done, 1);
    chk("add_idle_busy", busy, 0);

    // Single sub on requester 1.
    req1_valid = 1; req1_a = 32'h40A0_0000; req1_b = 32'h3F80_0000; req1_op = 0;
    rsp1_ready = 1;
    #1;
    chk("sub_req1_ready", req1_ready, 1);
    cyc();
    req1_valid = 0;
    chk("sub_dp_op", dp_op, 0);
    chk("sub_dp_a", dp_a, 32'h40A0_0000);
    cyc();
    chk("sub_rsp1_valid", rsp1_valid, 1);
    chk("sub_rsp1_result", rsp1_result, 32'h4080_0000);
    chk("sub_rsp0_valid", rsp0_valid, 0);
    chk("sub_rsp0_hold", rsp0_result, 32'h4070_0000);
    cyc();
    chk("sub_ops_done", ops_done, 2);

    // Both requesters held valid: grants alternate 0,1,0,1.
    req0_valid = 1; req0_a = 32'h3FC0_0000; req0_b = 32'h4010_0000; req0_op = 1;
    req1_valid = 1; req1_a = 32'h40A0_0000; req1_b = 32'h3F80_0000; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      int t;
      logic exp_g;
      t = 0;
      exp_g = logic'(k % 2);
      while (!(req0_ready || req1_ready) && t < 10) begin
        cyc();
        t++;
      end
      chk("rr_ready_seen", 32'(req0_ready || req1_ready), 1);
      chk("rr_grant1", req1_ready, 32'(exp_g));
      chk("rr_grant0", req0_ready, 32'(!exp_g));
      cyc();
      cyc();
      chk("rr_rsp0_valid", rsp0_valid, 32'(!exp_g));
      chk("rr_rsp1_valid", rsp1_valid, 32'(exp_g));
      if (exp_g) chk("rr_rsp1_result", rsp1_result, 32'h4080_0000);
      else       chk("rr_rsp0_result", rsp0_result, 32'h4070_0000);
      cyc();
      chk("rr_ops_done", ops_done, 32'(3 + k));
    end

    // Backpressure on requester 0 while requester 1 keeps asking.
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    chk("bp_req0_ready", req0_ready, 1);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      rsp1_ready = 1;
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_rsp0_result", rsp0_result, 32'h4070_0000);
      chk("bp_busy", busy, 1);
      chk("bp_req1_ready", req1_ready, 0);
      chk("bp_rsp1_valid", rsp1_valid, 0);
      chk("bp_rsp1_hold", rsp1_result, 32'h4080_0000);
      cyc();
    end
    rsp0_ready = 1;
    #1;
    chk("bp_still_resp", rsp0_valid, 1);
    cyc();
    chk("bp_after_req1_ready", req1_ready, 1);
    chk("bp_after_req0_ready", req0_ready, 0);
    chk("bp_ops_done", ops_done, 7);
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;

    // DP_LATENCY=3: four EXEC cycles, only the last dp_result is captured.
    x3_req0_valid = 1; x3_req0_a = 32'h7FC0_0001; x3_req0_b = 32'h0; x3_req0_op = 1;
    x3_dp_result = 32'hDEAD_BEEF;
    #1;
    chk("lat3_req0_ready", x3_req0_ready, 1);
    cyc();
    x3_req0_valid = 0;
    x3_req0_a = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk("lat3_exec_rsp0_valid", x3_rsp0_valid, 0);
      chk("lat3_exec_busy", x3_busy, 1);
      x3_dp_result = (i == 3) ? 32'h7FC0_0001 : (32'hDEAD_0000 + 32'(i));
      cyc();
    end
    chk("lat3_rsp0_valid", x3_rsp0_valid, 1);
    chk("lat3_rsp0_result", x3_rsp0_result, 32'h7FC0_0001);
    chk("lat3_dp_a_hold", x3_dp_a, 32'h7FC0_0001);
    x3_dp_result = 32'hFFFF_FFFF;
    x3_rsp0_ready = 1;
    #1;
    chk("lat3_result_stable", x3_rsp0_result, 32'h7FC0_0001);
    cyc();
    chk("lat3_ops_done", x3_ops_done, 1);
    chk("lat3_done_valid", x3_rsp0_valid, 0);
    x3_rsp0_ready = 0;

    // Reset while in EXEC: operation dropped, tie goes to requester 0 after.
    req1_valid = 1; req1_a = 32'h40A0_0000; req1_b = 32'h3F80_0000; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    cyc();
    chk("rex_exec_busy", busy, 1);
    req0_valid = 1;
    rst_n = 0;
    #1;
    chk("rex_busy", busy, 0);
    chk("rex_rsp0_valid", rsp0_valid, 0);
    chk("rex_rsp1_valid", rsp1_valid, 0);
    chk("rex_ops_done", ops_done, 0);
    chk("rex_dp_a", dp_a, 0);
    chk("rex_ready_low", 32'(req0_ready || req1_ready), 0);
    #1;
    rst_n = 1;
    #1;
    chk("rex_tie_req0_ready", req0_ready, 1);
    chk("rex_tie_req1_ready", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
Two-requester round-robin scheduler that shares one floating-point add/sub datapath (operands a, b, operation_select, result; operation_select 1 = add, 0 = subtract). Each requester issues operations through a valid/ready request channel and receives its result through a valid/ready response channel. The block registers operands, drives the datapath for a parameterised number of cycles, and captures the result. It returns the result to the requester that issued the operation.

Parameters:
WIDTH, 32, operand/result width (IEEE-754 single when 32)
DP_LATENCY, 0, extra cycles the datapath needs after operands are stable (0 = combinational datapath)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  block accepts requester 0 operation this cycle
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_op  input  1  requester 0 operation (1 add, 0 sub)
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
rsp0_valid  output  1  result available for requester 0
rsp0_ready  input  1  requester 0 consumes result
rsp0_result  output  WIDTH  result for requester 0
rsp1_valid / rsp1_ready / rsp1_result  same as requester 0, for requester 1
dp_a  output  WIDTH  operand a to shared datapath
dp_b  output  WIDTH  operand b to shared datapath
dp_op  output  1  operation_select to shared datapath
dp_result  input  WIDTH  result from shared datapath
busy  output  1  high whenever state != IDLE
ops_done  output  CNT_W  count of completed response handshakes

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - Operand registers, dp_a, dp_b, dp_op, result register and ops_done are cleared to 0.
  - All valid/ready outputs go to 0 (ready outputs return once IDLE is evaluated with rst_n high).
  - last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester 0 if only req0_valid; requester 1 if only req1_valid; if both, the requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational from valid and state; the non-granted requester's ready is 0.
  - On valid&&ready: latch a, b, op into operand registers, record owner, set last_grant = owner, load wait counter with DP_LATENCY, go to EXEC.
  - No request: stay in IDLE.
- dp_a, dp_b, dp_op come directly from the operand registers. They are stable from the cycle after acceptance until the next acceptance, and hold their last value in IDLE and RESP.
- EXEC:
  - If counter != 0, decrement it and stay in EXEC.
  - If counter == 0, capture dp_result into the result register and go to RESP.
  - EXEC therefore lasts exactly DP_LATENCY+1 cycles.
- RESP:
  - rspOWNER_valid = 1; rspOWNER_result = result register, stable while valid is held.
  - Non-owner rsp valid = 0; its result output holds its last delivered value.
  - On rspOWNER_ready: go to IDLE and increment ops_done, which wraps modulo 2^CNT_W.
  - Non-owner rsp_ready is ignored.
- Timing:
  - Minimum occupancy per operation is DP_LATENCY+3 cycles (accept, EXEC, RESP with immediate ready).
  - Accept-to-rsp_valid latency is DP_LATENCY+1 cycles.
  - A new request cannot be accepted in the same cycle a response handshake completes.
- Request valid dropped before handshake: no effect, nothing is latched. Request inputs are sampled only on the accept cycle, so changes during EXEC/RESP are ignored.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is produced, and ops_done is cleared.
- The block performs no arithmetic: results pass through bit-exact (including NaN/Inf/denormal encodings).

Test Plan:
- Single add: req0 a=0x3FC00000 (1.5), b=0x40100000 (2.25), op=1, DP_LATENCY=0 -> req0_ready same cycle; rsp0_valid 1 cycle after accept; rsp0_result=0x40700000 (3.75); ops_done=1.
- Single sub: req1 a=0x40A00000 (5.0), b=0x3F800000 (1.0), op=0 -> dp_op=0; rsp1_result=0x40800000 (4.0); rsp0_valid stays 0.
- Simultaneous requests held valid for 4 operations, rsp_ready tied high -> grant order 0,1,0,1; each response goes to the correct port; ops_done=4.
- Backpressure: rsp0_ready low for 5 cycles in RESP -> rsp0_valid and rsp0_result stable; busy=1; req1_ready=0 throughout; accept only after the handshake.
- DP_LATENCY=3 -> EXEC lasts 4 cycles; dp_result captured on the 4th EXEC cycle; a dp_result glitch on earlier cycles does not appear in rsp_result.
- Reset asserted in EXEC -> immediately busy=0, rsp valids 0, ops_done=0; after release a tie grants requester 0 first.
